// File: rtl/word_entry.sv
// Word entry: edit a letter with adj/dir, commit it into a multi-slot word,
// backspace with del, and hand the full word downstream over valid/ready.
module word_entry #(
  parameter int unsigned WORD_LEN   = 5,
  parameter int unsigned CHAR_W     = 7,
  parameter int unsigned FIRST_CHAR = 65,
  parameter int unsigned LAST_CHAR  = 90,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adj,
  input  logic                       dir,
  input  logic                       let_sel,
  input  logic                       del,
  input  logic                       submit,
  input  logic                       word_ready,
  output logic [CHAR_W-1:0]          cur_char,
  output logic [WORD_LEN*CHAR_W-1:0] word,
  output logic [CNT_W-1:0]           fill_cnt,
  output logic                       full,
  output logic                       word_valid
);

  localparam logic [CHAR_W-1:0] FIRST_C    = CHAR_W'(FIRST_CHAR);
  localparam logic [CHAR_W-1:0] LAST_C     = CHAR_W'(LAST_CHAR);
  localparam logic [CNT_W-1:0]  WORD_LEN_C = CNT_W'(WORD_LEN);

  typedef enum logic {EDIT, OFFER} state_t;

  state_t                           state_q, state_d;
  logic [CHAR_W-1:0]                cur_q, cur_d;
  logic [WORD_LEN-1:0][CHAR_W-1:0]  slots_q, slots_d;
  logic [CNT_W-1:0]                 fill_q, fill_d;
  logic                             in_range;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    slots_d  = slots_q;
    fill_d   = fill_q;
    in_range = (cur_q >= FIRST_C) && (cur_q <= LAST_C);

    case (state_q)
      EDIT: begin
        // Single action per cycle: del > let_sel > submit > adj.
        if (del) begin
          if (fill_q != '0) begin
            for (int unsigned k = 0; k < WORD_LEN; k++) begin
              if (CNT_W'(k + 1) == fill_q) slots_d[k] = '0;
            end
            fill_d = fill_q - CNT_W'(1);
          end
        end else if (let_sel) begin
          if (fill_q < WORD_LEN_C) begin
            for (int unsigned k = 0; k < WORD_LEN; k++) begin
              if (CNT_W'(k) == fill_q) slots_d[k] = cur_q;
            end
            fill_d = fill_q + CNT_W'(1);
          end
        end else if (submit) begin
          if (fill_q == WORD_LEN_C) state_d = OFFER;
        end else if (adj) begin
          if (!dir) cur_d = (cur_q == LAST_C)  ? FIRST_C : cur_q + CHAR_W'(1);
          else      cur_d = (cur_q == FIRST_C) ? LAST_C  : cur_q - CHAR_W'(1);
        end
        // Out-of-range recovery wins over any adj step.
        if (!in_range) cur_d = FIRST_C;
      end
      OFFER: begin
        if (word_ready) begin
          slots_d = '0;
          fill_d  = '0;
          state_d = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EDIT;
      cur_q   <= FIRST_C;
      slots_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      slots_q <= slots_d;
      fill_q  <= fill_d;
    end
  end

  assign cur_char   = cur_q;
  assign word       = slots_q;
  assign fill_cnt   = fill_q;
  assign full       = (fill_q == WORD_LEN_C);
  assign word_valid = (state_q == OFFER);

endmodule
